// File: rtl/excep_ctrl.sv
// Trap sequencer: qualifies exceptions, interrupts, debug entry and returns on the
// instruction in execute, writes the trap CSRs one per cycle, then redirects fetch.
module excep_ctrl #(
    parameter logic [31:0] DEBUG_HALT_ADDR  = 32'h0000_0800,
    parameter logic [31:0] DEBUG_EXCEP_ADDR = 32'h0000_0808
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_addr_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        illegal_i,
    input  logic        mret_i,
    input  logic        dret_i,
    input  logic        irq_timer_i,
    input  logic        irq_ext_i,
    input  logic        trigger_match_i,
    input  logic        halt_req_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] dpc_i,
    input  logic [31:0] dcsr_i,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        stall_o,
    output logic        redirect_o,
    output logic [31:0] redirect_addr_o,
    output logic        debug_mode_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_W_MEPC, S_W_MCAUSE, S_W_MSTATUS, S_W_DPC, S_W_DCSR, S_ASSERT
    } state_e;

    typedef enum logic [2:0] {
        K_TRAP, K_MRET, K_DBG, K_DRET, K_DEXC
    } kind_e;

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  dcause_q, dcause_d;
    logic        debug_q, debug_d;
    logic        csr_we_q, csr_we_d;
    logic [31:0] csr_waddr_q, csr_waddr_d;
    logic [31:0] csr_wdata_q, csr_wdata_d;
    logic        redirect_q, redirect_d;
    logic [31:0] raddr_q, raddr_d;
    logic        accept_s;
    logic        unused_s;

    function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r        = m;
        r[7]     = m[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[3] = m[7];
        r[7] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] dcsr_with_cause(input logic [31:0] d, input logic [2:0] c);
        logic [31:0] r;
        r      = d;
        r[8:6] = c;
        return r;
    endfunction

    assign unused_s = ^{mtvec_i[1:0], mie_i[31:12], mie_i[10:8], mie_i[6:0]};

    // Event qualification, event latch and sequence state transitions.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cause_d  = cause_q;
        dcause_d = dcause_q;
        accept_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!inst_valid_i) begin
                    state_d = S_IDLE;
                end else if (!debug_q && (halt_req_i || trigger_match_i || (ebreak_i && dcsr_i[15]))) begin
                    accept_s = 1'b1;
                    kind_d   = K_DBG;
                    dcause_d = halt_req_i ? 3'd3 : (trigger_match_i ? 3'd2 : 3'd1);
                    state_d  = S_W_DPC;
                end else if (illegal_i || ecall_i || ebreak_i) begin
                    accept_s = 1'b1;
                    if (debug_q) begin
                        kind_d  = K_DEXC;
                        state_d = S_ASSERT;
                    end else begin
                        kind_d  = K_TRAP;
                        cause_d = illegal_i ? 32'd2 : (ecall_i ? 32'd11 : 32'd3);
                        state_d = S_W_MEPC;
                    end
                end else if (dret_i) begin
                    accept_s = 1'b1;
                    if (debug_q) begin
                        kind_d  = K_DRET;
                        state_d = S_ASSERT;
                    end else begin
                        kind_d  = K_TRAP;
                        cause_d = 32'd2;
                        state_d = S_W_MEPC;
                    end
                end else if (mret_i) begin
                    accept_s = 1'b1;
                    kind_d   = K_MRET;
                    state_d  = S_W_MSTATUS;
                end else if (mstatus_i[3] && !debug_q &&
                             ((irq_ext_i && mie_i[11]) || (irq_timer_i && mie_i[7]))) begin
                    accept_s = 1'b1;
                    kind_d   = K_TRAP;
                    cause_d  = (irq_ext_i && mie_i[11]) ? 32'h8000_000B : 32'h8000_0007;
                    state_d  = S_W_MEPC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_W_MEPC:    state_d = S_W_MCAUSE;
            S_W_MCAUSE:  state_d = S_W_MSTATUS;
            S_W_MSTATUS: state_d = S_ASSERT;
            S_W_DPC:     state_d = S_W_DCSR;
            S_W_DCSR:    state_d = S_ASSERT;
            S_ASSERT:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        pc_d = accept_s ? inst_addr_i : pc_q;
    end

    // Output values for the state being entered, so every output leaves a flop.
    always_comb begin
        csr_we_d    = 1'b0;
        csr_waddr_d = 32'h0000_0000;
        csr_wdata_d = 32'h0000_0000;
        redirect_d  = 1'b0;
        raddr_d     = 32'h0000_0000;
        debug_d     = debug_q;
        case (state_d)
            S_W_MEPC: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = 32'h0000_0341;
                csr_wdata_d = pc_d;
            end
            S_W_MCAUSE: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = 32'h0000_0342;
                csr_wdata_d = cause_d;
            end
            S_W_MSTATUS: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = 32'h0000_0300;
                csr_wdata_d = (kind_d == K_MRET) ? mret_mstatus(mstatus_i) : trap_mstatus(mstatus_i);
            end
            S_W_DPC: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = 32'h0000_07B1;
                csr_wdata_d = pc_d;
            end
            S_W_DCSR: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = 32'h0000_07B0;
                csr_wdata_d = dcsr_with_cause(dcsr_i, dcause_d);
            end
            S_ASSERT: begin
                redirect_d = 1'b1;
                case (kind_d)
                    K_TRAP:  raddr_d = {mtvec_i[31:2], 2'b00};
                    K_MRET:  raddr_d = mepc_i;
                    K_DBG:   raddr_d = DEBUG_HALT_ADDR;
                    K_DRET:  raddr_d = dpc_i;
                    K_DEXC:  raddr_d = DEBUG_EXCEP_ADDR;
                    default: raddr_d = 32'h0000_0000;
                endcase
                if (kind_d == K_DBG) begin
                    debug_d = 1'b1;
                end else if (kind_d == K_DRET) begin
                    debug_d = 1'b0;
                end else begin
                    debug_d = debug_q;
                end
            end
            default: begin
                csr_we_d = 1'b0;
            end
        endcase
    end

    // State, event latch and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            kind_q      <= K_TRAP;
            cause_q     <= 32'h0000_0000;
            pc_q        <= 32'h0000_0000;
            dcause_q    <= 3'd0;
            debug_q     <= 1'b0;
            csr_we_q    <= 1'b0;
            csr_waddr_q <= 32'h0000_0000;
            csr_wdata_q <= 32'h0000_0000;
            redirect_q  <= 1'b0;
            raddr_q     <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cause_q     <= cause_d;
            pc_q        <= pc_d;
            dcause_q    <= dcause_d;
            debug_q     <= debug_d;
            csr_we_q    <= csr_we_d;
            csr_waddr_q <= csr_waddr_d;
            csr_wdata_q <= csr_wdata_d;
            redirect_q  <= redirect_d;
            raddr_q     <= raddr_d;
        end
    end

    // Stall rises in the accepting cycle itself, so it must see the live event.
    assign stall_o         = (state_q != S_IDLE) | (accept_s & ~rst);
    assign csr_we_o        = csr_we_q;
    assign csr_waddr_o     = csr_waddr_q;
    assign csr_wdata_o     = csr_wdata_q;
    assign redirect_o      = redirect_q;
    assign redirect_addr_o = raddr_q;
    assign debug_mode_o    = debug_q;

endmodule
